// File: rtl/prog_clock_divider.sv
// prog_clock_divider
//
// Programmable clock divider. It produces a registered divided clock whose
// period (div) and high-phase length (high) are counted in clk cycles. New
// div/high values can be loaded at any time. They are applied at once while
// the divider is idle. While it runs, they are held in a shadow register and
// applied at the next period boundary, so the output never shows a runt
// pulse. When en is dropped, the period in progress still completes before
// the divider goes idle.
//
// Ports
//   clk       in   system clock; all logic runs on the rising edge
//   rst       in   synchronous, active-high reset
//   en        in   run request, sampled on every edge
//   div_in    in   requested period in clk cycles (CNT_W bits)
//   high_in   in   requested high-phase length in clk cycles (CNT_W bits)
//   div_load  in   one-cycle strobe that captures div_in/high_in
//   clk_out   out  registered divided clock
//   tick      out  one-cycle pulse on each clk_out rising edge
//   running   out  high while the FSM is in RUN or DRAIN
//   pending   out  high while a captured load waits for a period boundary
module prog_clock_divider #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = 10,
  parameter int DEFAULT_HIGH = DEFAULT_DIV / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_reg,    state_next;
  logic [CNT_W-1:0] cnt_reg,      cnt_next;
  logic             clk_out_reg,  clk_out_next;
  logic             tick_reg,     tick_next;
  logic             pending_reg,  pending_next;
  logic [CNT_W-1:0] div_act_reg,  div_act_next;
  logic [CNT_W-1:0] high_act_reg, high_act_next;
  logic [CNT_W-1:0] div_shd_reg,  div_shd_next;
  logic [CNT_W-1:0] high_shd_reg, high_shd_next;

  // Sanitised versions of the load inputs. The high phase is clamped after
  // the divisor so that it always leaves at least one low cycle.
  logic [CNT_W-1:0] load_div;
  logic [CNT_W-1:0] load_high;

  // Period boundary and the cycle where the high phase ends.
  logic             wrap;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    load_div = div_in;
    if (div_in < CNT_W'(2)) begin
      load_div = CNT_W'(2);
    end
    load_high = high_in;
    if (high_in == '0) begin
      load_high = CNT_W'(1);
    end
    if (load_high >= load_div) begin
      load_high = load_div - CNT_W'(1);
    end
  end

  // cnt never exceeds div_act-1 <= 2^CNT_W-2, so cnt+1 cannot overflow.
  assign cnt_inc = cnt_reg + CNT_W'(1);
  assign wrap    = (cnt_reg == (div_act_reg - CNT_W'(1)));

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      clk_out_reg  <= 1'b0;
      tick_reg     <= 1'b0;
      pending_reg  <= 1'b0;
      div_act_reg  <= CNT_W'(DEFAULT_DIV);
      high_act_reg <= CNT_W'(DEFAULT_HIGH);
      div_shd_reg  <= '0;
      high_shd_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      clk_out_reg  <= clk_out_next;
      tick_reg     <= tick_next;
      pending_reg  <= pending_next;
      div_act_reg  <= div_act_next;
      high_act_reg <= high_act_next;
      div_shd_reg  <= div_shd_next;
      high_shd_reg <= high_shd_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    clk_out_next  = clk_out_reg;
    tick_next     = 1'b0;
    pending_next  = pending_reg;
    div_act_next  = div_act_reg;
    high_act_next = high_act_reg;
    div_shd_next  = div_shd_reg;
    high_shd_next = high_shd_reg;

    case (state_reg)
      IDLE: begin
        cnt_next     = '0;
        clk_out_next = 1'b0;
        pending_next = 1'b0;
        // Nothing is being generated, so a load can take effect at once.
        if (div_load) begin
          div_act_next  = load_div;
          high_act_next = load_high;
        end
        if (en) begin
          state_next   = RUN;
          clk_out_next = 1'b1;
          tick_next    = 1'b1;
        end
      end

      RUN, DRAIN: begin
        if (wrap) begin
          cnt_next = '0;
          // A load on the wrap edge itself feeds the next period directly
          // and takes precedence over an older shadowed load.
          if (div_load) begin
            div_act_next  = load_div;
            high_act_next = load_high;
            pending_next  = 1'b0;
          end else if (pending_reg) begin
            div_act_next  = div_shd_reg;
            high_act_next = high_shd_reg;
            pending_next  = 1'b0;
          end
          if ((state_reg == RUN) || en) begin
            // A new period starts. A RUN period that ends with en low
            // still starts this period and drains it before going idle.
            state_next   = en ? RUN : DRAIN;
            clk_out_next = 1'b1;
            tick_next    = 1'b1;
          end else begin
            state_next   = IDLE;
            clk_out_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == high_act_reg) begin
            clk_out_next = 1'b0;
          end
          // Mid-period loads wait in the shadow; a later load overwrites it.
          if (div_load) begin
            div_shd_next  = load_div;
            high_shd_next = load_high;
            pending_next  = 1'b1;
          end
          state_next = en ? RUN : DRAIN;
        end
      end

      default: begin
        state_next   = IDLE;
        cnt_next     = '0;
        clk_out_next = 1'b0;
        pending_next = 1'b0;
      end
    endcase
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign pending = pending_reg;
  assign running = (state_reg == RUN) || (state_reg == DRAIN);

endmodule

// File: tb/tb_prog_clock_divider.sv
// Testbench for prog_clock_divider. It applies directed stimulus and checks
// the DUT outputs on every cycle against a period-level reference model. It
// also checks hand-computed waveform properties such as tick counts, high
// cycle counts and the pending flag at chosen points.
module tb_prog_clock_divider;
  localparam int CNT_W = 16;
  localparam int DEF_DIV = 10;
  localparam int DEF_HIGH = 5;

  logic clk = 1'b0;
  logic rst, en, div_load;
  logic [CNT_W-1:0] div_in, high_in;
  logic clk_out, tick, running, pending;

  int n_checks = 0;
  int n_fail = 0;

  // Counters of sampled output activity, used by the literal checks.
  int tick_count = 0;
  int high_count = 0;
  int pend_count = 0;
  int s_t, s_h, s_p;

  // Reference model: an active period of m_pd cycles with m_ph high cycles.
  // m_pos is the position inside that period.
  bit m_active = 0;
  bit m_stop = 0;
  bit m_tick = 0;
  int m_pos = 0;
  int m_pd = DEF_DIV;
  int m_ph = DEF_HIGH;
  bit m_qv = 0;
  int m_qd = 0;
  int m_qh = 0;

  prog_clock_divider #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV), .DEFAULT_HIGH(DEF_HIGH)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .high_in(high_in),
    .div_load(div_load), .clk_out(clk_out), .tick(tick), .running(running),
    .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic int san_div(int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int san_high(int d, int h);
    int r;
    r = (h == 0) ? 1 : h;
    if (r >= san_div(d)) r = san_div(d) - 1;
    return r;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The inputs change only at negedge+1, so at a negedge they still hold the
  // values the previous rising edge sampled. The model therefore advances
  // here first and the outputs are compared against it afterwards.
  always @(negedge clk) begin
    if (rst) begin
      m_active = 0; m_stop = 0; m_tick = 0; m_pos = 0;
      m_pd = DEF_DIV; m_ph = DEF_HIGH; m_qv = 0;
    end else if (!m_active) begin
      m_tick = 0;
      if (div_load) begin
        m_pd = san_div(int'(div_in));
        m_ph = san_high(int'(div_in), int'(high_in));
      end
      if (en) begin
        m_active = 1; m_stop = 0; m_pos = 0; m_tick = 1;
      end
    end else if (m_pos == m_pd - 1) begin
      if (div_load) begin
        m_pd = san_div(int'(div_in));
        m_ph = san_high(int'(div_in), int'(high_in));
        m_qv = 0;
      end else if (m_qv) begin
        m_pd = m_qd; m_ph = m_qh; m_qv = 0;
      end
      m_pos = 0;
      if (m_stop && !en) begin
        m_active = 0; m_tick = 0;
      end else begin
        m_tick = 1;
      end
      m_stop = !en;
    end else begin
      m_pos++;
      m_tick = 0;
      if (div_load) begin
        m_qd = san_div(int'(div_in));
        m_qh = san_high(int'(div_in), int'(high_in));
        m_qv = 1;
      end
      m_stop = !en;
    end

    cmp("model_clk_out", int'(clk_out), int'(m_active && (m_pos < m_ph)));
    cmp("model_tick", int'(tick), int'(m_tick));
    cmp("model_running", int'(running), int'(m_active));
    cmp("model_pending", int'(pending), int'(m_qv));

    if (tick) tick_count++;
    if (clk_out) high_count++;
    if (pending) pend_count++;
  end

  task automatic wait_s(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic snap();
    s_t = tick_count; s_h = high_count; s_p = pend_count;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; en = 0; div_load = 0; div_in = '0; high_in = '0;
    wait_s(2);
    cmp("reset_clk_out", int'(clk_out), 0);
    cmp("reset_running", int'(running), 0);
    cmp("reset_pending", int'(pending), 0);
    cmp("reset_tick", int'(tick), 0);

    // Defaults 10/5 with en held high.
    rst = 0; en = 1; snap();
    wait_s(1);
    cmp("start_tick", int'(tick), 1);
    cmp("start_clk_out", int'(clk_out), 1);
    cmp("start_running", int'(running), 1);
    wait_s(39);
    cmp("def_ticks_40", tick_count - s_t, 4);
    cmp("def_high_40", high_count - s_h, 20);

    // Load 3/1 at cnt=2; the current 10-cycle period finishes first.
    wait_s(3);
    div_load = 1; div_in = 3; high_in = 1;
    wait_s(1);
    div_load = 0;
    cmp("load31_pending", int'(pending), 1);
    wait_s(6);
    cmp("load31_pending_end", int'(pending), 1);
    cmp("load31_low_end", int'(clk_out), 0);
    snap();
    wait_s(1);
    cmp("load31_tick", int'(tick), 1);
    cmp("load31_pending_clr", int'(pending), 0);
    wait_s(8);
    cmp("p31_ticks_9", tick_count - s_t, 3);
    cmp("p31_high_9", high_count - s_h, 3);

    // In IDLE, the load 1/0 is sanitised to 2/1.
    rst = 1; en = 0;
    wait_s(1);
    rst = 0; div_load = 1; div_in = 1; high_in = 0;
    wait_s(1);
    div_load = 0;
    cmp("idle_load_pending", int'(pending), 0);
    cmp("idle_load_running", int'(running), 0);
    en = 1; snap();
    wait_s(1);
    cmp("p21_first_hi", int'(clk_out), 1);
    cmp("p21_first_tick", int'(tick), 1);
    wait_s(1);
    cmp("p21_second_lo", int'(clk_out), 0);
    cmp("p21_second_tick", int'(tick), 0);
    wait_s(6);
    cmp("p21_ticks_8", tick_count - s_t, 4);
    cmp("p21_high_8", high_count - s_h, 4);

    // Reset at cnt=3 of a 7/3 period; a simultaneous load is ignored.
    rst = 1; en = 0;
    wait_s(1);
    rst = 0; div_load = 1; div_in = 7; high_in = 3; en = 1;
    wait_s(1);
    div_load = 0;
    cmp("p73_start_tick", int'(tick), 1);
    wait_s(3);
    cmp("p73_cnt3_lo", int'(clk_out), 0);
    rst = 1; div_load = 1; div_in = 4; high_in = 2;
    wait_s(1);
    cmp("midrst_clk_out", int'(clk_out), 0);
    cmp("midrst_running", int'(running), 0);
    cmp("midrst_pending", int'(pending), 0);
    rst = 0; div_load = 0; snap();
    wait_s(1);
    cmp("restart_tick", int'(tick), 1);
    wait_s(9);
    cmp("restart_ticks_10", tick_count - s_t, 1);
    cmp("restart_high_10", high_count - s_h, 5);
    wait_s(1);
    cmp("restart_period_tick", int'(tick), 1);

    // Drop en at cnt=1; the period drains, then the divider idles.
    wait_s(1);
    en = 0; snap();
    wait_s(8);
    cmp("drain_high", high_count - s_h, 3);
    cmp("drain_ticks", tick_count - s_t, 0);
    cmp("drain_running", int'(running), 1);
    wait_s(1);
    cmp("drained_running", int'(running), 0);
    cmp("drained_clk_out", int'(clk_out), 0);
    snap();
    wait_s(10);
    cmp("idle_ticks", tick_count - s_t, 0);
    cmp("idle_high", high_count - s_h, 0);

    // Load 4/2 on the wrap edge of a 10/5 period.
    en = 1;
    wait_s(1);
    cmp("p42_prev_tick", int'(tick), 1);
    wait_s(9);
    div_load = 1; div_in = 4; high_in = 2; snap();
    wait_s(1);
    div_load = 0;
    cmp("wrapload_tick", int'(tick), 1);
    wait_s(7);
    cmp("wrapload_ticks_8", tick_count - s_t, 2);
    cmp("wrapload_high_8", high_count - s_h, 4);
    cmp("wrapload_no_pend", pend_count - s_p, 0);

    // Two mid-period loads: only the second (5/2) is applied.
    wait_s(2);
    div_load = 1; div_in = 6; high_in = 3;
    wait_s(1);
    div_in = 5; high_in = 2;
    wait_s(1);
    div_load = 0;
    cmp("dbl_pending", int'(pending), 1);
    snap();
    wait_s(1);
    cmp("dbl_tick", int'(tick), 1);
    wait_s(9);
    cmp("dbl_ticks_10", tick_count - s_t, 2);
    cmp("dbl_high_10", high_count - s_h, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the divisor, high-time and internal counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 10: divisor loaded by reset, legal range 2..2^CNT_W-1.
REQ-003 SHALL have parameter DEFAULT_HIGH, default DEFAULT_DIV/2: high-phase length loaded by reset, legal range 1..DEFAULT_DIV-1.
REQ-004 clk  input  1  single system clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  run request; sampled every clk edge.
REQ-007 div_in  input  CNT_W  requested period in clk cycles.
REQ-008 high_in  input  CNT_W  requested high-phase length in clk cycles.
REQ-009 div_load  input  1  single-cycle strobe that captures div_in and high_in.
REQ-010 clk_out  output  1  registered divided clock.
REQ-011 tick  output  1  registered one-cycle pulse, coincident with each clk_out rising edge.
REQ-012 running  output  1  high in states RUN and DRAIN.
REQ-013 pending  output  1  high while a captured load awaits the next period boundary.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DRAIN, with internal counter cnt and active registers div_act and high_act.
REQ-015 SHALL sanitise each captured load: div<2 becomes 2; high=0 becomes 1; high>=div becomes div-1 (after div sanitising).
REQ-016 IDLE: cnt=0, clk_out=0, tick=0. On an edge with en=1: go to RUN; after that edge cnt=0, clk_out=1, tick=1.
REQ-017 RUN/DRAIN: on each edge, if cnt==div_act-1 (wrap) then cnt<=0, else cnt<=cnt+1.
REQ-018 SHALL set clk_out<=0 on the edge where cnt+1==high_act; clk_out holds its value otherwise except at wrap.
REQ-019 On a wrap in RUN: clk_out<=1 and tick<=1; the period is exactly div_act cycles, of which high_act are high.
REQ-020 tick SHALL be 0 in every cycle other than those named in REQ-016 and REQ-019.
REQ-021 RUN with en=0 at an edge -> DRAIN; the current period completes unchanged.
REQ-022 DRAIN with en=1 -> RUN, with no interruption of the waveform.
REQ-023 DRAIN at a wrap with en=0 -> IDLE, with clk_out=0 and no tick; clk_out is never truncated.
REQ-024 div_load in IDLE: sanitised values go directly into div_act and high_act on that edge; pending stays 0.
REQ-025 div_load in RUN/DRAIN, not on a wrap: values are captured into shadow registers and pending<=1.
REQ-026 At a wrap with pending=1: shadow -> active, pending<=0; the new period uses the new values.
REQ-027 div_load on the same edge as a wrap: the incoming values take effect for the period starting at that wrap; pending stays 0.
REQ-028 A second div_load while pending=1 SHALL overwrite the shadow; only the last load is applied.
REQ-029 Active values SHALL never change mid-period, so clk_out has no runt pulses.
REQ-030 Counter compare arithmetic SHALL be CNT_W bits wide; cnt SHALL never exceed div_act-1.

Reset
REQ-031 rst=1 at an edge forces the following, overriding all other inputs including en and div_load:
- state=IDLE, cnt=0, clk_out=0, tick=0, running=0, pending=0;
- div_act=DEFAULT_DIV, high_act=DEFAULT_HIGH, shadow cleared.
REQ-032 Reset asserted mid-period SHALL take effect on that edge; the truncated period is accepted.
REQ-033 The first edge with rst=0 and en=1 SHALL behave per REQ-016.

Verification
REQ-034 Reset, then en=1 held, defaults 10/5 -> clk_out 5 cycles high, 5 low, repeating; tick every 10th cycle; first tick on the edge after en is sampled.
REQ-035 While running at 10/5, div_load with div_in=3, high_in=1 at cnt=2 -> pending=1 until wrap; current 10-cycle period completes; then 1 high, 2 low, repeating.
REQ-036 div_load with div_in=1, high_in=0 in IDLE -> active values 2/1; with en=1, clk_out toggles every cycle and tick fires every 2 cycles.
REQ-037 en dropped at cnt=1 of a 10/5 period -> DRAIN; clk_out completes 5 high, 5 low; then IDLE, running=0, clk_out stays 0, no further tick.
REQ-038 rst pulsed at cnt=3 while running at 7/3 -> the next cycle shows clk_out=0, running=0, pending=0; with en held, restart uses 10/5.
REQ-039 div_load (div_in=4, high_in=2) on the wrap edge of a 10/5 period -> the immediately following period is 2 high, 2 low; pending never rises.
